// File: rtl/crc_qsys_nios2_gen2_0_cpu_debug_mem_arbiter_pkg.sv
// Shared types and constants for the debug-memory arbiter.
// Covers the FSM states, the RAM geometry and the JTAG jdo field positions.
package crc_qsys_nios2_gen2_0_cpu_debug_mem_arbiter_pkg;

    localparam int RAM_AW = 8;
    localparam int DW     = 32;
    localparam int BEW    = DW / 8;
    localparam int JDO_W  = 38;

    localparam int JDO_ADDR_MSB  = 9;
    localparam int JDO_ADDR_LSB  = 2;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WR_BIT    = 35;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        JTAG_ACC = 2'd1,
        CPU_ACC  = 2'd2,
        RD_WAIT  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              wr;
        logic [RAM_AW-1:0] addr;
        logic [DW-1:0]     wdata;
    } jtag_req_t;

    function automatic logic [RAM_AW-1:0] jdo_addr(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
    endfunction

    function automatic logic [DW-1:0] jdo_wdata(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    endfunction

    function automatic logic jdo_wr(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_WR_BIT];
    endfunction

endpackage

// File: rtl/crc_qsys_nios2_gen2_0_cpu_debug_rr_arb.sv
// Two-way round-robin grant between the JTAG and CPU requesters.
// On a tie the grant goes to whichever side was not granted last.
module crc_qsys_nios2_gen2_0_cpu_debug_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic req_jtag,
    input  logic req_cpu,
    input  logic advance,
    output logic gnt_jtag,
    output logic gnt_cpu
);

    logic last_cpu;

    always_comb begin
        gnt_jtag = req_jtag & (~req_cpu | last_cpu);
        gnt_cpu  = req_cpu & ~gnt_jtag;
    end

    // Last-grant starts as CPU so JTAG wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_cpu <= 1'b1;
        end else if (advance && (gnt_jtag || gnt_cpu)) begin
            last_cpu <= gnt_cpu;
        end
    end

endmodule

// File: rtl/crc_qsys_nios2_gen2_0_cpu_debug_mem_arbiter.sv
// Shares the on-chip debug RAM between the JTAG debug port and the CPU Avalon slave.
// One access at a time; reads take an extra RD_WAIT cycle for the RAM's registered output.
module crc_qsys_nios2_gen2_0_cpu_debug_mem_arbiter
    import crc_qsys_nios2_gen2_0_cpu_debug_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [JDO_W-1:0]  jdo,
    output logic [DW-1:0]     jtag_rdata,
    output logic              jtag_rdata_valid,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    input  logic [RAM_AW-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DW-1:0]     avs_writedata,
    input  logic [BEW-1:0]    avs_byteenable,
    input  logic              avs_debugaccess,
    output logic [DW-1:0]     avs_readdata,
    output logic              avs_waitrequest,
    output logic              ram_cs,
    output logic              ram_wren,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    output logic [BEW-1:0]    ram_be,
    input  logic [DW-1:0]     ram_rdata
);

    arb_state_t        state;
    logic [RAM_AW-1:0] jtag_addr;
    logic              jtag_pend;
    jtag_req_t         jtag_req;
    logic              rd_for_cpu;
    logic              cpu_wr;

    logic [RAM_AW-1:0] load_addr;
    logic              new_jtag;
    jtag_req_t         jtag_req_eff;
    logic              jtag_req_vis;
    logic              cpu_req;
    logic              gnt_jtag;
    logic              gnt_cpu;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_WR_BIT+1], jdo[JDO_ADDR_LSB-1:0]};

    // A strobe arriving this cycle is visible to the arbiter immediately, so a
    // same-cycle CPU request really is a tie; a coincident address load wins.
    always_comb begin
        load_addr    = take_action_ocimem_a ? jdo_addr(jdo) : jtag_addr;
        new_jtag     = take_action_ocimem_b & ~jtag_pend;
        jtag_req_eff = jtag_req;
        if (new_jtag) begin
            jtag_req_eff.wr    = jdo_wr(jdo);
            jtag_req_eff.addr  = load_addr;
            jtag_req_eff.wdata = jdo_wdata(jdo);
        end
        jtag_req_vis = jtag_pend | new_jtag;
        cpu_req      = avs_read | avs_write;
    end

    crc_qsys_nios2_gen2_0_cpu_debug_rr_arb u_rr_arb (
        .clk      (clk),
        .reset    (reset),
        .req_jtag (jtag_req_vis),
        .req_cpu  (cpu_req),
        .advance  (state == IDLE),
        .gnt_jtag (gnt_jtag),
        .gnt_cpu  (gnt_cpu)
    );

    assign jtag_busy    = jtag_pend;
    assign avs_readdata = (state == RD_WAIT && rd_for_cpu) ? ram_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            jtag_addr        <= '0;
            jtag_pend        <= 1'b0;
            jtag_req         <= '0;
            jtag_overrun     <= 1'b0;
            jtag_rdata       <= '0;
            jtag_rdata_valid <= 1'b0;
            rd_for_cpu       <= 1'b0;
            cpu_wr           <= 1'b0;
            ram_cs           <= 1'b0;
            ram_wren         <= 1'b0;
            ram_addr         <= '0;
            ram_wdata        <= '0;
            ram_be           <= '0;
            avs_waitrequest  <= 1'b1;
        end else begin
            jtag_rdata_valid <= 1'b0;

            if (new_jtag) begin
                jtag_pend <= 1'b1;
                jtag_req  <= jtag_req_eff;
            end
            if (take_action_ocimem_b && jtag_pend) begin
                jtag_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (gnt_jtag) begin
                        state     <= JTAG_ACC;
                        ram_cs    <= 1'b1;
                        ram_wren  <= jtag_req_eff.wr;
                        ram_addr  <= jtag_req_eff.addr;
                        ram_wdata <= jtag_req_eff.wdata;
                        ram_be    <= '1;
                    end else if (gnt_cpu) begin
                        // Writes without debugaccess still handshake, just never strobe the RAM.
                        state           <= CPU_ACC;
                        cpu_wr          <= avs_write;
                        ram_cs          <= 1'b1;
                        ram_wren        <= avs_write & avs_debugaccess;
                        ram_addr        <= avs_address;
                        ram_wdata       <= avs_writedata;
                        ram_be          <= avs_byteenable;
                        avs_waitrequest <= ~avs_write;
                    end
                end

                JTAG_ACC: begin
                    ram_cs   <= 1'b0;
                    ram_wren <= 1'b0;
                    ram_be   <= '0;
                    if (jtag_req.wr) begin
                        state     <= IDLE;
                        jtag_pend <= 1'b0;
                        jtag_addr <= jtag_addr + 8'd1;
                    end else begin
                        state      <= RD_WAIT;
                        rd_for_cpu <= 1'b0;
                    end
                end

                CPU_ACC: begin
                    ram_cs   <= 1'b0;
                    ram_wren <= 1'b0;
                    ram_be   <= '0;
                    if (cpu_wr) begin
                        state           <= IDLE;
                        avs_waitrequest <= 1'b1;
                    end else begin
                        state           <= RD_WAIT;
                        rd_for_cpu      <= 1'b1;
                        avs_waitrequest <= 1'b0;
                    end
                end

                RD_WAIT: begin
                    state           <= IDLE;
                    avs_waitrequest <= 1'b1;
                    if (!rd_for_cpu) begin
                        jtag_rdata       <= ram_rdata;
                        jtag_rdata_valid <= 1'b1;
                        jtag_pend        <= 1'b0;
                        jtag_addr        <= jtag_addr + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase

            // A fresh address load from the debugger overrides the post-access increment.
            if (take_action_ocimem_a) begin
                jtag_addr    <= jdo_addr(jdo);
                jtag_overrun <= take_action_ocimem_b & jtag_pend;
            end
        end
    end

endmodule

// File: tb/tb_crc_qsys_nios2_gen2_0_cpu_debug_mem_arbiter.sv
// Scoreboard bench for the debug-memory arbiter: stimulus pushes expected RAM
// accesses and read data into queues, a monitor pops and compares them.
module tb_crc_qsys_nios2_gen2_0_cpu_debug_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [37:0] jdo;
    logic [31:0] jtag_rdata;
    logic        jtag_rdata_valid;
    logic        jtag_busy;
    logic        jtag_overrun;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        avs_debugaccess;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        ram_cs;
    logic        ram_wren;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;

    typedef struct {
        logic [7:0] addr;
        logic       wren;
    } ram_exp_t;

    ram_exp_t    ram_q[$];
    logic [31:0] cpu_q[$];
    logic [31:0] jtag_q[$];
    int          n_compared = 0;
    int          n_mismatched = 0;
    int          lat_cpu;

    logic [31:0] mem [0:255];
    logic        mem_ready = 1'b0;

    crc_qsys_nios2_gen2_0_cpu_debug_mem_arbiter dut (
        .clk                  (clk),
        .reset                (reset),
        .take_action_ocimem_a (take_action_ocimem_a),
        .take_action_ocimem_b (take_action_ocimem_b),
        .jdo                  (jdo),
        .jtag_rdata           (jtag_rdata),
        .jtag_rdata_valid     (jtag_rdata_valid),
        .jtag_busy            (jtag_busy),
        .jtag_overrun         (jtag_overrun),
        .avs_address          (avs_address),
        .avs_read             (avs_read),
        .avs_write            (avs_write),
        .avs_writedata        (avs_writedata),
        .avs_byteenable       (avs_byteenable),
        .avs_debugaccess      (avs_debugaccess),
        .avs_readdata         (avs_readdata),
        .avs_waitrequest      (avs_waitrequest),
        .ram_cs               (ram_cs),
        .ram_wren             (ram_wren),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .ram_be               (ram_be),
        .ram_rdata            (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: word i starts as 32'hA50000ii; read data is registered.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= {24'hA50000, i[7:0]};
            mem_ready <= 1'b1;
        end else if (ram_cs === 1'b1) begin
            if (ram_wren === 1'b1) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s", name);
    endtask

    // Monitor: every RAM strobe, CPU read completion and JTAG valid pulse must match the queues.
    initial begin
        ram_exp_t e;
        forever begin
            @(negedge clk);
            if (ram_cs === 1'b1) begin
                if (ram_q.size() == 0) report_fail("ram access not expected");
                else begin
                    e = ram_q.pop_front();
                    checkOutput("ram_addr", {24'h0, ram_addr}, {24'h0, e.addr});
                    checkOutput("ram_wren", {31'h0, ram_wren}, {31'h0, e.wren});
                end
            end
            if (avs_read === 1'b1 && avs_waitrequest === 1'b0) begin
                if (cpu_q.size() == 0) report_fail("cpu read completion not expected");
                else checkOutput("avs_readdata", avs_readdata, cpu_q.pop_front());
            end
            if (jtag_rdata_valid === 1'b1) begin
                if (jtag_q.size() == 0) report_fail("jtag_rdata_valid not expected");
                else checkOutput("jtag_rdata", jtag_rdata, jtag_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [37:0] mk_addr(input logic [7:0] a);
        return {28'h0, a, 2'b00};
    endfunction

    function automatic logic [37:0] mk_acc(input logic wr, input logic [31:0] d);
        return {2'b00, wr, d, 3'b000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ram(input logic [7:0] a, input logic w);
        ram_exp_t e;
        e.addr = a;
        e.wren = w;
        ram_q.push_back(e);
    endtask

    // Drives the JTAG strobes for one clock cycle.
    task automatic applyStimulus(input logic load, input logic access, input logic [37:0] jdo_value);
        jdo = jdo_value;
        take_action_ocimem_a = load;
        take_action_ocimem_b = access;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic wait_jtag_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (jtag_busy === 1'b0) done = 1;
        end
        if (!done) report_fail({name, " jtag_busy timeout"});
        tick();
    endtask

    task automatic jtag_access(input logic wr, input logic [31:0] d, input string name);
        applyStimulus(1'b0, 1'b1, mk_acc(wr, d));
        wait_jtag_idle(name);
    endtask

    task automatic cpu_read(input logic [7:0] a, output int lat);
        avs_address = a;
        avs_read = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (avs_waitrequest === 1'b0 || lat >= 30) break;
        end
        if (avs_waitrequest !== 1'b0) report_fail("cpu_read waitrequest timeout");
        tick();
        avs_read = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic dbg, output int lat);
        avs_address = a;
        avs_writedata = d;
        avs_byteenable = be;
        avs_debugaccess = dbg;
        avs_write = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (avs_waitrequest === 1'b0 || lat >= 30) break;
        end
        if (avs_waitrequest !== 1'b0) report_fail("cpu_write waitrequest timeout");
        tick();
        avs_write = 1'b0;
        avs_debugaccess = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        jdo = '0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        avs_debugaccess = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset avs_waitrequest", {31'h0, avs_waitrequest}, 32'h1);
        checkOutput("reset ram_cs", {31'h0, ram_cs}, 32'h0);
        checkOutput("reset ram_wren", {31'h0, ram_wren}, 32'h0);
        checkOutput("reset ram_be", {28'h0, ram_be}, 32'h0);
        checkOutput("reset jtag_busy", {31'h0, jtag_busy}, 32'h0);
        checkOutput("reset jtag_overrun", {31'h0, jtag_overrun}, 32'h0);
        checkOutput("reset jtag_rdata_valid", {31'h0, jtag_rdata_valid}, 32'h0);
        checkOutput("reset jtag_rdata", jtag_rdata, 32'h0);
        checkOutput("reset avs_readdata", avs_readdata, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] JTAG write then read at 0x10");
        applyStimulus(1'b1, 1'b0, mk_addr(8'h10));
        push_ram(8'h10, 1'b1);
        jtag_access(1'b1, 32'hDEADBEEF, "jtag write 0x10");
        applyStimulus(1'b1, 1'b0, mk_addr(8'h10));
        push_ram(8'h10, 1'b0);
        jtag_q.push_back(32'hDEADBEEF);
        jtag_access(1'b0, 32'h0, "jtag read 0x10");
        push_ram(8'h11, 1'b0);
        jtag_q.push_back(32'hA5000011);
        jtag_access(1'b0, 32'h0, "jtag read 0x11");

        $display("[TB] coincident address load and read at 0x70");
        push_ram(8'h70, 1'b0);
        jtag_q.push_back(32'hA5000070);
        applyStimulus(1'b1, 1'b1, mk_addr(8'h70) | mk_acc(1'b0, 32'h0));
        wait_jtag_idle("jtag coincident read");

        $display("[TB] CPU read latency and discarded write");
        push_ram(8'h20, 1'b0);
        cpu_q.push_back(32'hA5000020);
        cpu_read(8'h20, lat_cpu);
        checkOutput("cpu read latency", lat_cpu, 32'd3);
        push_ram(8'h20, 1'b0);
        cpu_write(8'h20, 32'h12345678, 4'hF, 1'b0, lat_cpu);
        checkOutput("cpu write latency", lat_cpu, 32'd2);
        @(negedge clk);
        checkOutput("waitrequest after write", {31'h0, avs_waitrequest}, 32'h1);
        tick();
        push_ram(8'h20, 1'b0);
        cpu_q.push_back(32'hA5000020);
        cpu_read(8'h20, lat_cpu);
        push_ram(8'h21, 1'b1);
        cpu_write(8'h21, 32'h12345678, 4'b0011, 1'b1, lat_cpu);
        push_ram(8'h21, 1'b0);
        cpu_q.push_back(32'hA5005678);
        cpu_read(8'h21, lat_cpu);

        $display("[TB] contention after reset");
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, mk_addr(8'h30));
        push_ram(8'h30, 1'b0);
        push_ram(8'h40, 1'b0);
        jtag_q.push_back(32'hA5000030);
        cpu_q.push_back(32'hA5000040);
        fork
            jtag_access(1'b0, 32'h0, "tie1 jtag");
            cpu_read(8'h40, lat_cpu);
        join
        checkOutput("tie1 cpu latency", lat_cpu, 32'd6);
        push_ram(8'h31, 1'b0);
        jtag_q.push_back(32'hA5000031);
        jtag_access(1'b0, 32'h0, "jtag read 0x31");
        push_ram(8'h41, 1'b0);
        push_ram(8'h32, 1'b0);
        cpu_q.push_back(32'hA5000041);
        jtag_q.push_back(32'hA5000032);
        fork
            jtag_access(1'b0, 32'h0, "tie2 jtag");
            cpu_read(8'h41, lat_cpu);
        join
        checkOutput("tie2 cpu latency", lat_cpu, 32'd3);

        $display("[TB] address wrap");
        applyStimulus(1'b1, 1'b0, mk_addr(8'hFF));
        push_ram(8'hFF, 1'b1);
        jtag_access(1'b1, 32'hCAFEF00D, "jtag write 0xFF");
        push_ram(8'h00, 1'b0);
        jtag_q.push_back(32'hA5000000);
        jtag_access(1'b0, 32'h0, "jtag read after wrap");

        $display("[TB] overrun");
        applyStimulus(1'b1, 1'b0, mk_addr(8'h50));
        push_ram(8'h50, 1'b0);
        jtag_q.push_back(32'hA5000050);
        applyStimulus(1'b0, 1'b1, mk_acc(1'b0, 32'h0));
        applyStimulus(1'b0, 1'b1, mk_acc(1'b1, 32'h11111111));
        @(negedge clk);
        checkOutput("overrun set", {31'h0, jtag_overrun}, 32'h1);
        checkOutput("busy during overrun", {31'h0, jtag_busy}, 32'h1);
        wait_jtag_idle("overrun read");
        checkOutput("overrun sticky", {31'h0, jtag_overrun}, 32'h1);
        applyStimulus(1'b1, 1'b0, mk_addr(8'h60));
        @(negedge clk);
        checkOutput("overrun cleared", {31'h0, jtag_overrun}, 32'h0);
        tick();

        $display("[TB] reset during CPU read");
        push_ram(8'h22, 1'b0);
        avs_address = 8'h22;
        avs_read = 1'b1;
        tick();
        reset = 1'b1;
        avs_read = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("post-reset waitrequest", {31'h0, avs_waitrequest}, 32'h1);
            checkOutput("post-reset ram_cs", {31'h0, ram_cs}, 32'h0);
        end
        tick();

        checkOutput("ram queue drained", ram_q.size(), 32'd0);
        checkOutput("cpu queue drained", cpu_q.size(), 32'd0);
        checkOutput("jtag queue drained", jtag_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
